// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Glyph table, segment bit positions and the all-dark pattern.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-high segments g..a for a hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Modulo-DIV counter; tick is high on the last count of each period.
// Used for both the digit scan rate and the blink rate.
module seg_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic RSTN,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed seven-segment driver with shadowed, frame-aligned updates.
// Optional PWM dimming via SEG_DIMMING_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  RSTN,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     dig_en,
    input  logic [DIGITS-1:0]     flash_en,
    input  logic [3:0]            brightness,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic scan_tick, blink_tick, wrap, duty;

    logic [IW-1:0]       idx_q, idx_d;
    logic                slot0_q, slot0_d;
    logic                blink_q, blink_d;
    logic                frame_q, frame_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic [DIGITS-1:0]   sh_fl_q, sh_fl_d, act_fl_q, act_fl_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          nib;
    logic                dp_sel, vis;

    seg_prescaler #(.DIV(SCAN_DIV)) u_scan (
        .clk  (clk),
        .RSTN (RSTN),
        .tick (scan_tick)
    );

    seg_prescaler #(.DIV(BLINK_DIV)) u_blink (
        .clk  (clk),
        .RSTN (RSTN),
        .tick (blink_tick)
    );

`ifdef SEG_DIMMING_EN
    logic [3:0] pwm_q;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) pwm_q <= '0;
        else       pwm_q <= pwm_q + 4'd1;
    end

    assign duty = (pwm_q <= brightness);
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign duty = 1'b1;
`endif

    assign wrap = scan_tick && (idx_q == IDX_LAST);

    always_comb begin
        idx_d = idx_q;
        if (scan_tick) idx_d = wrap ? '0 : idx_q + IW'(1);
        slot0_d = scan_tick;
        blink_d = blink_tick ? ~blink_q : blink_q;
        frame_d = wrap;
        // A load on the wrap cycle keeps pending set for the next frame
        pend_d = load ? 1'b1 : (wrap ? 1'b0 : pend_q);

        sh_data_d = sh_data_q;
        sh_dp_d   = sh_dp_q;
        sh_en_d   = sh_en_q;
        sh_fl_d   = sh_fl_q;
        if (load) begin
            sh_data_d = data;
            sh_dp_d   = dp;
            sh_en_d   = dig_en;
            sh_fl_d   = flash_en;
        end

        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        act_fl_d   = act_fl_q;
        if (wrap && pend_q) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            act_en_d   = sh_en_q;
            act_fl_d   = sh_fl_q;
        end

        nib    = '0;
        dp_sel = 1'b0;
        vis    = 1'b0;
        an_d   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib     = act_data_q[4*i +: 4];
                dp_sel  = act_dp_q[i];
                vis     = act_en_q[i] & ~(act_fl_q[i] & blink_q);
                an_d[i] = ~(vis & ~slot0_q & duty);
            end
        end
        seg_d = {~dp_sel, ~hex7(nib)};
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            idx_q      <= '0;
            slot0_q    <= 1'b1;
            blink_q    <= 1'b0;
            frame_q    <= 1'b0;
            pend_q     <= 1'b0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_en_q    <= '0;
            sh_fl_q    <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
            act_fl_q   <= '0;
            seg_q      <= SEG_OFF;
            an_q       <= '1;
        end else begin
            idx_q      <= idx_d;
            slot0_q    <= slot0_d;
            blink_q    <= blink_d;
            frame_q    <= frame_d;
            pend_q     <= pend_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_en_q    <= sh_en_d;
            sh_fl_q    <= sh_fl_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            act_fl_q   <= act_fl_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a 4-digit fast-scan instance plus
// a 64-cycle-slot instance for the duty-cycle check.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  dig_en = '0;
    logic [3:0]  flash_en = '0;
    logic [3:0]  brightness = 4'hF;
    logic [7:0]  seg, seg2;
    logic [3:0]  an, an2;
    logic        ft, ft2, pend, pend2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    logic [15:0] m_data;
    logic [3:0]  m_dp, m_en, m_fl;

    always #5 clk = ~clk;

    always @(posedge clk or negedge RSTN)
        if (!RSTN) cyc <= 0;
        else       cyc <= cyc + 1;

    seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(32)) dut (
        .clk        (clk),
        .RSTN       (RSTN),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .dig_en     (dig_en),
        .flash_en   (flash_en),
        .brightness (brightness),
        .seg        (seg),
        .an         (an),
        .frame_tick (ft),
        .pending    (pend)
    );

    seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(64), .BLINK_DIV(32)) dut_dim (
        .clk        (clk),
        .RSTN       (RSTN),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .dig_en     (dig_en),
        .flash_en   (flash_en),
        .brightness (brightness),
        .seg        (seg2),
        .an         (an2),
        .frame_tick (ft2),
        .pending    (pend2)
    );

    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    // Expected outputs seen after posedge n (they reflect state after n-1 edges)
    function automatic logic [3:0] exp_an(input int n);
        int m, c, i, ph;
        logic v;
        m  = n - 1;
        c  = m % 4;
        i  = (m / 4) % 4;
        ph = (m / 32) % 2;
        v  = m_en[i] & ~(m_fl[i] & (ph == 1));
        if (c == 0 || !v) return 4'hF;
        return ~(4'b0001 << i);
    endfunction

    function automatic logic [7:0] exp_seg(input int n);
        int i;
        logic [7:0] g;
        i = ((n - 1) / 4) % 4;
        g = glyph(m_data[4*i +: 4]);
        return {~m_dp[i], g[6:0]};
    endfunction

    task automatic wait_frame(input bit which, input int bound, output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(which ? ft2 : ft) && w < bound);
        if (!(which ? ft2 : ft)) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_timeout inst=%0d waited=%0d", which, w);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] e, input logic [3:0] f);
        data = d;
        dp = p;
        dig_en = e;
        flash_en = f;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        int w, bad;
        repeat (3) @(negedge clk);
        n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL rst_an got=%h exp=F", an); end
        n_cmp++; if (seg !== 8'hFF) begin n_err++; $display("FAIL rst_seg got=%h exp=FF", seg); end
        n_cmp++; if (ft !== 1'b0) begin n_err++; $display("FAIL rst_ft got=%b exp=0", ft); end
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL rst_pend got=%b exp=0", pend); end
        @(negedge clk) RSTN = 1'b1;
        do_load(16'h8888, 4'h0, 4'hF, 4'h0);
        wait_frame(0, 40, w);
        repeat (2) @(negedge clk);
        n_cmp++; if (an !== 4'b1110) begin n_err++; $display("FAIL pre_rst_an got=%b exp=1110", an); end
        do_load(16'h1234, 4'h0, 4'hF, 4'h0);
        #2 RSTN = 1'b0;
        #1;
        n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL midrst_an got=%h exp=F", an); end
        n_cmp++; if (seg !== 8'hFF) begin n_err++; $display("FAIL midrst_seg got=%h exp=FF", seg); end
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL midrst_pend got=%b exp=0", pend); end
        n_cmp++; if (ft !== 1'b0) begin n_err++; $display("FAIL midrst_ft got=%b exp=0", ft); end
        @(negedge clk) RSTN = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (an !== 4'hF || pend !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL dark_after_rst bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_load();
        int w, bad;
        wait_frame(0, 40, w);
        do_load(16'h1234, 4'h0, 4'hF, 4'h0);
        n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL load_pend got=%b exp=1", pend); end
        repeat (5) @(negedge clk);
        n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL load_pend_mid got=%b exp=1", pend); end
        wait_frame(0, 40, w);
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL commit_pend got=%b exp=0", pend); end
        @(negedge clk);
        n_cmp++; if (an !== 4'hF || seg !== 8'h99) begin n_err++; $display("FAIL guard0 an=%h seg=%h exp F/99", an, seg); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (an !== 4'b1110 || seg !== 8'h99) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL slot0 bad_cycles=%0d exp=0", bad); end
        @(negedge clk);
        n_cmp++; if (an !== 4'hF || seg !== 8'hB0) begin n_err++; $display("FAIL guard1 an=%h seg=%h exp F/B0", an, seg); end
        wait_frame(0, 40, w);
        n_cmp++; if (w != 11) begin n_err++; $display("FAIL frame_period got=%0d exp=11", w); end
    endtask

    task automatic test_back_to_back();
        int w, bad;
        wait_frame(0, 40, w);
        do_load(16'h1111, 4'h0, 4'hF, 4'h0);
        do_load(16'h2222, 4'h0, 4'hF, 4'h0);
        n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL b2b_pend got=%b exp=1", pend); end
        wait_frame(0, 40, w);
        bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (seg !== 8'hA4) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL last_wins bad_cycles=%0d exp=0", bad); end
        wait_frame(0, 40, w);
        do_load(16'h3333, 4'h0, 4'hF, 4'h0);
        repeat (14) @(negedge clk);
        data = 16'h4444;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_cmp++; if (ft !== 1'b1) begin n_err++; $display("FAIL coinc_ft got=%b exp=1", ft); end
        n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL coinc_pend got=%b exp=1", pend); end
        @(negedge clk);
        n_cmp++; if (seg !== 8'hB0) begin n_err++; $display("FAIL coinc_old seg=%h exp=B0", seg); end
        wait_frame(0, 40, w);
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL coinc_commit pend=%b exp=0", pend); end
        @(negedge clk);
        n_cmp++; if (seg !== 8'h99) begin n_err++; $display("FAIL coinc_new seg=%h exp=99", seg); end
    endtask

    task automatic test_blink();
        int w, bad, on0, on1, ph;
        wait_frame(0, 40, w);
        do_load(16'h1234, 4'h0, 4'hF, 4'b0010);
        wait_frame(0, 40, w);
        m_data = 16'h1234; m_dp = 4'h0; m_en = 4'hF; m_fl = 4'b0010;
        bad = 0; on0 = 0; on1 = 0;
        repeat (128) begin
            @(negedge clk);
            ph = ((cyc - 1) / 32) % 2;
            if (an !== exp_an(cyc)) bad++;
            if (an[1] === 1'b0) begin
                if (ph == 1) on1++;
                else         on0++;
            end
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL blink_an bad_cycles=%0d exp=0", bad); end
        n_cmp++; if (on1 != 0) begin n_err++; $display("FAIL blink_dark got=%0d exp=0", on1); end
        n_cmp++; if (on0 == 0) begin n_err++; $display("FAIL blink_lit got=%0d exp>0", on0); end
    endtask

    task automatic test_dp_enable();
        int w, bad, dark3, dpc;
        wait_frame(0, 40, w);
        do_load(16'h0000, 4'b0100, 4'b0111, 4'h0);
        wait_frame(0, 40, w);
        m_data = 16'h0000; m_dp = 4'b0100; m_en = 4'b0111; m_fl = 4'h0;
        bad = 0; dark3 = 0; dpc = 0;
        repeat (32) begin
            @(negedge clk);
            if (an !== exp_an(cyc) || seg !== exp_seg(cyc)) bad++;
            if (an[3] === 1'b0) dark3++;
            if (seg === 8'h40) dpc++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL dp_en_model bad_cycles=%0d exp=0", bad); end
        n_cmp++; if (dark3 != 0) begin n_err++; $display("FAIL dig3_dark got=%0d exp=0", dark3); end
        n_cmp++; if (dpc != 8) begin n_err++; $display("FAIL dp_cycles got=%0d exp=8", dpc); end
    endtask

    task automatic test_dimming();
        int w, low48, low63, other;
        brightness = 4'd3;
        wait_frame(1, 600, w);
        do_load(16'h1234, 4'h0, 4'hF, 4'h0);
        wait_frame(1, 600, w);
        n_cmp++; if (pend2 !== 1'b0) begin n_err++; $display("FAIL dim_pend got=%b exp=0", pend2); end
        @(negedge clk);
        n_cmp++; if (an2 !== 4'hF) begin n_err++; $display("FAIL dim_guard an=%h exp=F", an2); end
        low48 = 0; low63 = 0; other = 0;
        for (int k = 0; k < 63; k++) begin
            @(negedge clk);
            if (an2[0] === 1'b0) begin
                low63++;
                if (k < 48) low48++;
            end
            if (an2[3:1] !== 3'b111) other++;
        end
        n_cmp++; if (other != 0) begin n_err++; $display("FAIL dim_other got=%0d exp=0", other); end
`ifdef SEG_DIMMING_EN
        n_cmp++; if (low48 != 12) begin n_err++; $display("FAIL dim_duty got=%0d exp=12", low48); end
`else
        n_cmp++; if (low63 != 63) begin n_err++; $display("FAIL full_duty got=%0d exp=63", low63); end
`endif
        brightness = 4'hF;
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_blink();
        test_dp_enable();
        test_dimming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
